// File: rtl/gcd_driver.sv
// -----------------------------------------------------------------------------
// gcd_driver
//
// Initiator-side companion to the GCD engine. Takes operand pairs from an
// upstream valid/ready stream and hands them to the engine. Results come back
// valid-only, so they are caught in a small show-ahead FIFO and re-presented
// downstream on a valid/ready stream. Pairs with a zero operand are answered
// locally (A|B), because the engine never terminates on them.
//
// Ports:
//   clk           clock, all state on the rising edge
//   reset         asynchronous, active-low reset
//   req_valid     upstream request valid
//   req_data      [2W-1:W] operand A, [W-1:0] operand B
//   req_ready     request accepted on req_valid & req_ready
//   gcd_in_valid  to engine io_in_valid
//   gcd_in_data   to engine io_in_data (mirror of req_data)
//   gcd_in_ready  from engine io_in_ready
//   gcd_out_valid from engine io_out_valid (single-cycle pulse)
//   gcd_out_data  from engine io_out_data
//   resp_valid    downstream result valid (FIFO not empty)
//   resp_data     FIFO head (show-ahead)
//   resp_ready    downstream pop
//   busy          an operand pair is in flight in the engine (state WAIT)
//   err           sticky protocol error (spurious result or push into full FIFO)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. req_ready never looks at req_data or req_valid; resp_valid never
// looks at resp_ready. The engine output has no ready: its slot is reserved by
// requiring FIFO space before issuing, and nothing else pushes while in WAIT.
// -----------------------------------------------------------------------------
module gcd_driver #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  input  logic [2*WIDTH-1:0] req_data,
  output logic               req_ready,
  output logic               gcd_in_valid,
  output logic [2*WIDTH-1:0] gcd_in_data,
  input  logic               gcd_in_ready,
  input  logic               gcd_out_valid,
  input  logic [WIDTH-1:0]   gcd_out_data,
  output logic               resp_valid,
  output logic [WIDTH-1:0]   resp_data,
  input  logic               resp_ready,
  output logic               busy,
  output logic               err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;

  logic [WIDTH-1:0] op_a, op_b;
  logic             zero, space, accept, pop, push, overflow;
  logic             push_req, spurious;
  logic [WIDTH-1:0] push_data;

  assign op_a  = req_data[2*WIDTH-1:WIDTH];
  assign op_b  = req_data[WIDTH-1:0];
  assign zero  = (op_a == '0) | (op_b == '0);
  assign space = (count < FULL);

  // Gated by reset so both handshake outputs read 0 while reset is held,
  // whatever the engine drives on its ready line.
  assign req_ready    = reset & (state == S_IDLE) & space & gcd_in_ready;
  assign gcd_in_valid = reset & req_valid & (state == S_IDLE) & space & ~zero;
  assign gcd_in_data  = req_data;
  assign accept       = req_valid & req_ready;

  assign resp_valid = (count != '0);
  assign resp_data  = mem[rd_ptr];
  assign busy       = (state == S_WAIT);

  // Next state and push selection.
  always_comb begin
    state_nxt = state;
    push_req  = 1'b0;
    push_data = '0;
    spurious  = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (zero) begin
            // gcd(x,0)=x and gcd(0,0)=0, both equal to A|B.
            push_req  = 1'b1;
            push_data = op_a | op_b;
          end else begin
            state_nxt = S_WAIT;
          end
        end
        // Nothing is in the engine, so any result now is spurious.
        if (gcd_out_valid) spurious = 1'b1;
      end
      S_WAIT: begin
        if (gcd_out_valid) begin
          push_req  = 1'b1;
          push_data = gcd_out_data;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign pop      = resp_valid & resp_ready;
  assign push     = push_req & space;
  assign overflow = push_req & ~space;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (spurious | overflow) err <= 1'b1;
    end
  end

endmodule

// File: doc/gcd_driver.md
Name: gcd_driver

Overview:
- Initiator-side companion to the GCD engine. Accepts operand pairs from an upstream valid/ready stream and issues them to the engine's input handshake. The engine's output is valid-only, so this block captures each result into a buffer and re-presents it downstream on a valid/ready stream.
- Also handles zero-operand requests locally, because the engine never terminates on them, and keeps results in request order.

Parameters:
- WIDTH, 16, operand/result width; the engine's input bus is 2*WIDTH.
- DEPTH, 4, result FIFO entries (power of two, >=2).

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  upstream request valid.
- req_data  in  2*WIDTH  [2W-1:W]=operand A, [W-1:0]=operand B.
- req_ready  out  1  request accepted when req_valid&req_ready.
- gcd_in_valid  out  1  to engine io_in_valid.
- gcd_in_data  out  2*WIDTH  to engine io_in_data; equals req_data.
- gcd_in_ready  in  1  from engine io_in_ready.
- gcd_out_valid  in  1  from engine io_out_valid, single-cycle pulse.
- gcd_out_data  in  WIDTH  from engine io_out_data.
- resp_valid  out  1  downstream result valid (FIFO not empty).
- resp_data  out  WIDTH  FIFO head (show-ahead).
- resp_ready  in  1  downstream pop.
- busy  out  1  operation in flight in engine (state==WAIT).
- err  out  1  sticky protocol error.

Behaviour:
- Reset values, async on reset==0:
  - State IDLE; FIFO empty.
  - req_ready=0, gcd_in_valid=0, resp_valid=0, resp_data=0 (storage cleared), busy=0, err=0.
- States: IDLE (nothing in engine), WAIT (one operand pair in engine).
- Definitions:
  - space = (count < DEPTH).
  - zero = (A==0) | (B==0).
- req_ready: combinational, = (state==IDLE) & space & gcd_in_ready, in all cases.
  - It does not depend on req_data, so there is no data-dependent ready.
- gcd_in_valid: combinational, = req_valid & (state==IDLE) & space & ~zero.
- Non-zero request accepted at edge t:
  - Engine latches the pair at t.
  - State IDLE->WAIT.
- Zero request accepted at edge t:
  - Engine is not driven.
  - FIFO is pushed at t with the result: A|B (gcd(x,0)=x; gcd(0,0)=0).
  - resp_valid is high from t+1. State stays IDLE.
- In WAIT:
  - req_ready=0.
  - On gcd_out_valid=1, gcd_out_data is pushed at that edge and state WAIT->IDLE.
  - A new request can be accepted no earlier than the following cycle (one-cycle bubble, by design).
- Ordering: zero bypass only occurs in IDLE, so responses are strictly in request-acceptance order.
- Credit rule: issue/bypass requires space. While in WAIT, no other push can occur. The result slot is therefore always available; no flow control is needed toward the engine.
- FIFO:
  - Pop when resp_valid & resp_ready.
  - Push and pop in the same cycle: count unchanged, both take effect.
  - Pop when empty: ignored.
  - Pointers wrap modulo DEPTH.
  - count ranges 0..DEPTH.
- err: set and held until reset when either:
  - gcd_out_valid=1 while state==IDLE (spurious result; data discarded), or
  - a push is attempted with count==DEPTH (data discarded, count unchanged).
- Reset mid-operation:
  - All state clears, and in-flight and buffered results are lost.
  - The engine shares the reset domain, so it is cleared with the driver.
- Widths: no arithmetic beyond A|B and pointer increments; results are exactly WIDTH bits.

Test Plan:
- Basic: req (A=48,B=18), resp_ready=1 → gcd_in_valid pulses in the accept cycle; busy until engine pulse; resp_data=6, resp_valid for 1 cycle; then (A=17,B=5) → 1.
- Zero bypass: (0,7) → no gcd_in_valid, resp_data=7 one cycle after accept; (9,0) → 9; (0,0) → 0; busy stays 0.
- Backpressure: resp_ready=0, send (12,8),(0,3),(21,14),(10,0) → results 4,3,7,10 buffered; count=4, req_ready=0 with a 5th request pending. Raise resp_ready → results drain in order, then the 5th request is accepted.
- Ordering/bubble: (100,75) then (0,5) back-to-back with req_valid held → (0,5) is accepted only after the WAIT->IDLE cycle; responses 25 then 5.
- Simultaneous push/pop: FIFO at count=3, resp_ready=1 on the same edge as an engine result → count stays 3, head advances, no err.
- Reset/error: assert reset during WAIT → all outputs return to reset values immediately. Inject gcd_out_valid in IDLE → err=1 and stays 1; FIFO unchanged.
